// File: rtl/regfile_write_arbiter_if.sv
// Purpose : bundles the requester handshake and register-file write-port signals
//           so that the arbiter and its environment share a single port.
// Ports   : ReqValid/ReqReady/ReqData/ReqAddr (requester side),
//           WriteData/WriteRegister/RegWrite/GrantId/StallCount (regfile side).
//           slave = arbiter view, master = requester/regfile environment view.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STALL_W    = 16
) ();
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            ReqValid;
    logic [NUM_REQ-1:0]            ReqReady;
    logic [NUM_REQ*DATA_WIDTH-1:0] ReqData;
    logic [NUM_REQ*ADDR_WIDTH-1:0] ReqAddr;
    logic [DATA_WIDTH-1:0]         WriteData;
    logic [ADDR_WIDTH-1:0]         WriteRegister;
    logic                          RegWrite;
    logic [GID_W-1:0]              GrantId;
    logic [STALL_W-1:0]            StallCount;

    modport slave (
        input  ReqValid, ReqData, ReqAddr,
        output ReqReady, WriteData, WriteRegister, RegWrite, GrantId, StallCount
    );

    modport master (
        output ReqValid, ReqData, ReqAddr,
        input  ReqReady, WriteData, WriteRegister, RegWrite, GrantId, StallCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose : round-robin arbiter sharing one register-file write port among NUM_REQ writeback requesters.
// Latency : granted write appears on WriteData/WriteRegister/RegWrite one Clk edge after transfer.
// Backpr. : ReqReady is one-hot on the round-robin winner; losers hold ReqValid and retry; all-zero in Reset.
// Ports   : Clk, Reset (sync, active-high); bus (slave modport) carries the requester
//           handshake (ReqValid/ReqReady/ReqData/ReqAddr) and the regfile write port
//           (WriteData/WriteRegister/RegWrite) plus GrantId and the saturating StallCount.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STALL_W    = 16
) (
    input logic                     Clk,
    input logic                     Reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GID_W-1:0] LAST_IDX = GID_W'(NUM_REQ - 1);

    logic [GID_W-1:0]      ptr_q, ptr_d;
    logic [GID_W-1:0]      grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
    logic                  reg_write_q, reg_write_d;
    logic [STALL_W-1:0]    stall_q, stall_d;

    logic                  win_found;
    logic [GID_W-1:0]      win_idx;
    logic [GID_W-1:0]      scan_idx;
    logic [NUM_REQ-1:0]    ready;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  xfer;
    logic                  stall_now;

    // Round-robin scan starting at the priority pointer; the index wraps
    // explicitly so non-power-of-two requester counts work.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.ReqValid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

    // Reset masks the grant so a write offered during reset is never taken.
    always_comb begin
        ready = '0;
        if (win_found && !Reset) begin
            ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == GID_W'(i)) begin
                sel_data = bus.ReqData[i*DATA_WIDTH +: DATA_WIDTH];
                sel_addr = bus.ReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign xfer      = |ready;
    assign stall_now = |(bus.ReqValid & ~ready);

    always_comb begin
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        write_data_d = write_data_q;
        write_reg_d  = write_reg_q;
        reg_write_d  = 1'b0;
        stall_d      = stall_q;
        if (xfer) begin
            write_data_d = sel_data;
            write_reg_d  = sel_addr;
            grant_id_d   = win_idx;
            // Writes to the zero register are consumed but never reach the regfile.
            reg_write_d  = (sel_addr != '0);
            ptr_d        = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
        if (stall_now && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q        <= '0;
            grant_id_q   <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            stall_q      <= '0;
        end else begin
            ptr_q        <= ptr_d;
            grant_id_q   <= grant_id_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.ReqReady      = ready;
    assign bus.WriteData     = write_data_q;
    assign bus.WriteRegister = write_reg_q;
    assign bus.RegWrite      = reg_write_q;
    assign bus.GrantId       = grant_id_q;
    assign bus.StallCount    = stall_q;
endmodule
